// File: rtl/controle_tiros.sv
// controle_tiros: manages up to four player shots. Each shot spawns above
// the shooter, climbs one pixel per movement tick and disappears at the top
// or when a collision kill arrives. Spawns are rate-limited by a cooldown.
module controle_tiros #(
  parameter int DIV      = 50000,  // CLOCK_50 cycles per movement tick
  parameter int RECARGA  = 20,     // ticks of cooldown after each accepted shot
  parameter int OFFSET_Y = 15      // spawn height above the shooter
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        pausa,
  input  logic        reiniciarJogo,
  input  logic        disparo,
  input  logic [9:0]  xi,
  input  logic [9:0]  yi,
  input  logic [3:0]  acerto,
  output logic [39:0] tiros_x,
  output logic [39:0] tiros_y,
  output logic [3:0]  ativo,
  output logic        disparo_ack,
  output logic        cheio
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (RECARGA > 0) ? $clog2(RECARGA + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(DIV - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(RECARGA);
  localparam logic [9:0]    OFF_Y     = 10'(OFFSET_Y);

  typedef enum logic [1:0] {
    S_LIVRE   = 2'd0,
    S_ALOCA   = 2'd1,
    S_RECARGA = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [TW-1:0]  r_tick_cnt;
  logic [CW-1:0]  r_cool;
  logic [CW-1:0]  w_next_cool;
  logic           w_tick;
  logic           w_aloca;
  logic           w_tem_livre;
  logic [1:0]     w_idx;
  logic [9:0]     w_spawn_y;
  logic [9:0]     r_x [4];
  logic [9:0]     r_y [4];
  logic [3:0]     r_ativo;
  logic           r_ack;

  // Movement tick: one-cycle strobe every DIV cycles, frozen while paused.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (reiniciarJogo) begin
      r_tick_cnt <= '0;
    end else if (!pausa) begin
      r_tick_cnt <= (r_tick_cnt == TICK_MAX) ? '0 : r_tick_cnt + 1'b1;
    end
  end

  assign w_tick = !pausa && (r_tick_cnt == TICK_MAX);

  // Spawn height saturates at the top of the screen instead of wrapping.
  assign w_spawn_y = (yi >= OFF_Y) ? (yi - OFF_Y) : '0;

  // Lowest-index free slot; scanning downward lets the lowest index win.
  // NOTE: every combinational output gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_tem_livre = 1'b0;
    w_idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!r_ativo[k]) begin
        w_tem_livre = 1'b1;
        w_idx       = 2'(k);
      end
    end
  end

  // Spawn FSM state and cooldown registers; a game restart clears both.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_LIVRE;
      r_cool  <= '0;
    end else if (reiniciarJogo) begin
      r_state <= S_LIVRE;
      r_cool  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cool  <= w_next_cool;
    end
  end

  // Spawn FSM next state: request -> allocate -> cooldown -> free.
  always_comb begin
    w_next_state = r_state;
    w_next_cool  = r_cool;
    w_aloca      = 1'b0;
    case (r_state)
      S_LIVRE: begin
        if (disparo && !pausa && !cheio) w_next_state = S_ALOCA;
      end
      S_ALOCA: begin
        // A pause arriving mid-request holds the spawn until it ends.
        if (!pausa) begin
          if (w_tem_livre) begin
            w_aloca      = 1'b1;
            w_next_cool  = COOL_LOAD;
            w_next_state = S_RECARGA;
          end else begin
            w_next_state = S_LIVRE;
          end
        end
      end
      S_RECARGA: begin
        if (r_cool == '0)  w_next_state = S_LIVRE;
        else if (w_tick)   w_next_cool  = r_cool - 1'b1;
      end
      default: w_next_state = S_LIVRE;
    endcase
  end

  // Slot storage: kill beats spawn beats movement; inactive slots read as 0.
  // NOTE: the slot array is only four entries of flops, so it takes the
  // reset like any other register; large RAMs would not be reset this way.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_ativo <= '0;
      for (int k = 0; k < 4; k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
      end
    end else if (reiniciarJogo) begin
      r_ativo <= '0;
      for (int k = 0; k < 4; k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acerto[k] && r_ativo[k]) begin
          r_ativo[k] <= 1'b0;
          r_x[k]     <= '0;
          r_y[k]     <= '0;
        end else if (w_aloca && (w_idx == 2'(k))) begin
          r_ativo[k] <= 1'b1;
          r_x[k]     <= xi;
          r_y[k]     <= w_spawn_y;
        end else if (w_tick && r_ativo[k]) begin
          if (r_y[k] == '0) begin
            r_ativo[k] <= 1'b0;
            r_x[k]     <= '0;
          end else begin
            r_y[k] <= r_y[k] - 1'b1;
          end
        end
      end
    end
  end

  // Acknowledge is registered so it lines up with the slot write.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)              r_ack <= 1'b0;
    else if (reiniciarJogo) r_ack <= 1'b0;
    else                    r_ack <= w_aloca;
  end

  // Pack the slot registers onto the flat output buses.
  always_comb begin
    tiros_x = '0;
    tiros_y = '0;
    for (int k = 0; k < 4; k++) begin
      tiros_x[10*k +: 10] = r_x[k];
      tiros_y[10*k +: 10] = r_y[k];
    end
  end

  assign ativo       = r_ativo;
  assign cheio       = &r_ativo;
  assign disparo_ack = r_ack;

endmodule

// File: tb/tb_controle_tiros.sv
// Directed bench for controle_tiros with DIV=4, RECARGA=2, OFFSET_Y=15.
module tb_controle_tiros;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        pausa;
  logic        reiniciarJogo;
  logic        disparo;
  logic [9:0]  xi;
  logic [9:0]  yi;
  logic [3:0]  acerto;
  logic [39:0] tiros_x;
  logic [39:0] tiros_y;
  logic [3:0]  ativo;
  logic        disparo_ack;
  logic        cheio;

  int n_vec = 0;
  int n_bad = 0;

  controle_tiros #(.DIV(4), .RECARGA(2), .OFFSET_Y(15)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .pausa         (pausa),
    .reiniciarJogo (reiniciarJogo),
    .disparo       (disparo),
    .xi            (xi),
    .yi            (yi),
    .acerto        (acerto),
    .tiros_x       (tiros_x),
    .tiros_y       (tiros_y),
    .ativo         (ativo),
    .disparo_ack   (disparo_ack),
    .cheio         (cheio)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic        disp;
    logic        pau;
    logic        rein;
    logic [3:0]  ac;
    logic [9:0]  x_in;
    logic [9:0]  y_in;
    logic        ack;
    logic [3:0]  atv;
    logic [39:0] tx;
    logic [39:0] ty;
  } vec_t;

  localparam logic [9:0] Z = 10'd0;

  function automatic logic [39:0] pk(input logic [9:0] a3, input logic [9:0] a2,
                                     input logic [9:0] a1, input logic [9:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic d, input logic [3:0] ac,
                              input logic [9:0] x_in, input logic [9:0] y_in,
                              input logic ack, input logic [3:0] atv,
                              input logic [39:0] tx, input logic [39:0] ty);
    vec_t v;
    v.disp = d;    v.pau = 1'b0; v.rein = 1'b0; v.ac = ac;
    v.x_in = x_in; v.y_in = y_in;
    v.ack  = ack;  v.atv = atv;  v.tx = tx;     v.ty = ty;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // One clock edge, then settle away from it.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pausa = 1'b0; reiniciarJogo = 1'b0; disparo = 1'b0;
    xi = '0; yi = '0; acerto = '0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  // Steps until disparo_ack or the budget runs out; a timeout is a miscompare.
  task automatic wait_ack(input int budget, output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!disparo_ack && edges < budget);
    if (!disparo_ack) check("ack_timeout", 64'd0, 64'd1);
  endtask

  vec_t vt[18];
  int   e;
  int   n_ack;

  initial begin
    // Fire, climb, saturated spawn at the top, leave at y=0, kill (incl. inactive).
    vt[0]  = mk(1'b1, 4'h0, 10'd100, 10'd200, 1'b0, 4'b0000, pk(Z,Z,Z,Z), pk(Z,Z,Z,Z));
    vt[1]  = mk(1'b1, 4'h0, 10'd100, 10'd200, 1'b1, 4'b0001, pk(Z,Z,Z,10'd100), pk(Z,Z,Z,10'd185));
    vt[2]  = mk(1'b0, 4'h0, 10'd100, 10'd200, 1'b0, 4'b0001, pk(Z,Z,Z,10'd100), pk(Z,Z,Z,10'd185));
    vt[3]  = mk(1'b0, 4'h0, 10'd100, 10'd200, 1'b0, 4'b0001, pk(Z,Z,Z,10'd100), pk(Z,Z,Z,10'd184));
    vt[4]  = mk(1'b0, 4'h0, 10'd100, 10'd200, 1'b0, 4'b0001, pk(Z,Z,Z,10'd100), pk(Z,Z,Z,10'd184));
    vt[5]  = mk(1'b0, 4'h0, 10'd100, 10'd200, 1'b0, 4'b0001, pk(Z,Z,Z,10'd100), pk(Z,Z,Z,10'd184));
    vt[6]  = mk(1'b0, 4'h0, 10'd100, 10'd200, 1'b0, 4'b0001, pk(Z,Z,Z,10'd100), pk(Z,Z,Z,10'd184));
    vt[7]  = mk(1'b0, 4'h0, 10'd100, 10'd200, 1'b0, 4'b0001, pk(Z,Z,Z,10'd100), pk(Z,Z,Z,10'd183));
    vt[8]  = mk(1'b0, 4'h0, 10'd100, 10'd200, 1'b0, 4'b0001, pk(Z,Z,Z,10'd100), pk(Z,Z,Z,10'd183));
    vt[9]  = mk(1'b0, 4'h0, 10'd100, 10'd200, 1'b0, 4'b0001, pk(Z,Z,Z,10'd100), pk(Z,Z,Z,10'd183));
    vt[10] = mk(1'b1, 4'h0, 10'd300, 10'd10,  1'b0, 4'b0001, pk(Z,Z,Z,10'd100), pk(Z,Z,Z,10'd183));
    vt[11] = mk(1'b1, 4'h0, 10'd300, 10'd10,  1'b1, 4'b0011, pk(Z,Z,10'd300,10'd100), pk(Z,Z,Z,10'd182));
    vt[12] = mk(1'b0, 4'h0, 10'd300, 10'd10,  1'b0, 4'b0011, pk(Z,Z,10'd300,10'd100), pk(Z,Z,Z,10'd182));
    vt[13] = mk(1'b0, 4'h0, 10'd300, 10'd10,  1'b0, 4'b0011, pk(Z,Z,10'd300,10'd100), pk(Z,Z,Z,10'd182));
    vt[14] = mk(1'b0, 4'h0, 10'd300, 10'd10,  1'b0, 4'b0011, pk(Z,Z,10'd300,10'd100), pk(Z,Z,Z,10'd182));
    vt[15] = mk(1'b0, 4'h0, 10'd300, 10'd10,  1'b0, 4'b0001, pk(Z,Z,Z,10'd100), pk(Z,Z,Z,10'd181));
    vt[16] = mk(1'b0, 4'h3, 10'd300, 10'd10,  1'b0, 4'b0000, pk(Z,Z,Z,Z), pk(Z,Z,Z,Z));
    vt[17] = mk(1'b0, 4'h0, 10'd300, 10'd10,  1'b0, 4'b0000, pk(Z,Z,Z,Z), pk(Z,Z,Z,Z));

    do_reset();
    check("rst_ativo", 64'(ativo), 64'd0);
    check("rst_ack",   64'(disparo_ack), 64'd0);
    check("rst_x",     64'(tiros_x), 64'd0);
    check("rst_y",     64'(tiros_y), 64'd0);

    for (int i = 0; i < 18; i++) begin
      disparo = vt[i].disp; pausa = vt[i].pau; reiniciarJogo = vt[i].rein;
      acerto  = vt[i].ac;   xi    = vt[i].x_in; yi = vt[i].y_in;
      step();
      check($sformatf("v%0d_ack", i),   64'(disparo_ack), 64'(vt[i].ack));
      check($sformatf("v%0d_ativo", i), 64'(ativo),       64'(vt[i].atv));
      check($sformatf("v%0d_cheio", i), 64'(cheio),       64'd0);
      check($sformatf("v%0d_x", i),     64'(tiros_x),     64'(vt[i].tx));
      check($sformatf("v%0d_y", i),     64'(tiros_y),     64'(vt[i].ty));
    end

    // Held request fills slots in order, then full blocks further acks.
    do_reset();
    disparo = 1'b1; xi = 10'd50; yi = 10'd500;
    wait_ack(30, e);
    check("fill_latency", 64'(e), 64'd2);
    check("fill0_ativo", 64'(ativo), 64'b0001);
    wait_ack(30, e);
    check("fill1_ativo", 64'(ativo), 64'b0011);
    wait_ack(30, e);
    check("fill2_ativo", 64'(ativo), 64'b0111);
    wait_ack(30, e);
    check("fill3_ativo", 64'(ativo), 64'b1111);
    check("fill3_cheio", 64'(cheio), 64'd1);
    n_ack = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (disparo_ack) n_ack++;
    end
    check("full_no_ack", 64'(n_ack), 64'd0);
    xi = 10'd77; acerto = 4'b0010;
    step();
    acerto = 4'b0000;
    check("kill1_ativo", 64'(ativo), 64'b1101);
    check("kill1_cheio", 64'(cheio), 64'd0);
    wait_ack(30, e);
    check("refill_ativo", 64'(ativo), 64'b1111);
    check("refill_x", 64'(tiros_x), 64'(pk(10'd50, 10'd50, 10'd77, 10'd50)));

    // Pause freezes position, tick phase and cooldown; kill still works.
    do_reset();
    disparo = 1'b1; xi = 10'd5; yi = 10'd115;
    step();
    step();
    check("pz_ack", 64'(disparo_ack), 64'd1);
    check("pz_y0", 64'(tiros_y), 64'(pk(Z, Z, Z, 10'd100)));
    pausa = 1'b1;
    repeat (20) step();
    check("pz_frozen_y", 64'(tiros_y), 64'(pk(Z, Z, Z, 10'd100)));
    check("pz_frozen_ativo", 64'(ativo), 64'b0001);
    check("pz_no_ack", 64'(disparo_ack), 64'd0);
    acerto = 4'b0001;
    step();
    acerto = 4'b0000;
    check("pz_kill_ativo", 64'(ativo), 64'd0);
    check("pz_kill_x", 64'(tiros_x), 64'd0);
    pausa = 1'b0;
    wait_ack(30, e);
    check("pz_cool_resume", 64'(e), 64'd9);
    check("pz_new_ativo", 64'(ativo), 64'b0001);
    check("pz_new_y", 64'(tiros_y), 64'(pk(Z, Z, Z, 10'd100)));

    // Asynchronous reset clears state with no clock edge.
    reset = 1'b1;
    #2;
    check("async_ativo", 64'(ativo), 64'd0);
    check("async_y", 64'(tiros_y), 64'd0);
    do_reset();

    // Restart during cooldown with three shots in flight.
    disparo = 1'b1; xi = 10'd1; yi = 10'd300;
    wait_ack(30, e);
    wait_ack(30, e);
    wait_ack(30, e);
    check("rj_pre_ativo", 64'(ativo), 64'b0111);
    reiniciarJogo = 1'b1;
    step();
    reiniciarJogo = 1'b0;
    check("rj_ativo", 64'(ativo), 64'd0);
    check("rj_x", 64'(tiros_x), 64'd0);
    check("rj_y", 64'(tiros_y), 64'd0);
    check("rj_ack", 64'(disparo_ack), 64'd0);
    step();
    check("rj_aloca_ack", 64'(disparo_ack), 64'd0);
    step();
    check("rj_new_ack", 64'(disparo_ack), 64'd1);
    check("rj_new_ativo", 64'(ativo), 64'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/controle_tiros.md
CONTROLE_TIROS -- requirements
Module: controle_tiros

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, meaning CLOCK_50 cycles per movement tick.
REQ-002 The block SHALL have parameter RECARGA, default 20, meaning ticks of cooldown after each accepted shot.
REQ-003 The block SHALL have parameter OFFSET_Y, default 15, meaning the vertical spawn offset above yi.
REQ-004 CLOCK_50  input  1  system clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pausa  input  1  freezes movement, cooldown and new spawns while 1.
REQ-007 reiniciarJogo  input  1  synchronous clear of all shots and state.
REQ-008 disparo  input  1  fire request, held by the requester until disparo_ack.
REQ-009 xi  input  10  spawn x (shooter position).
REQ-010 yi  input  10  spawn y (shooter position).
REQ-011 acerto  input  4  per-slot collision kill, one bit per slot.
REQ-012 tiros_x  output  40  packed x of slots 3..0, slot k at bits [10k+9:10k].
REQ-013 tiros_y  output  40  packed y of slots 3..0, same packing.
REQ-014 ativo  output  4  per-slot active flag.
REQ-015 disparo_ack  output  1  one-cycle pulse when a shot is allocated.
REQ-016 cheio  output  1  1 when all four slots are active.

Function
REQ-017 Tick generator SHALL count 0..DIV-1 on CLOCK_50 and assert internal tick for exactly one cycle when the count equals DIV-1, then wrap to 0.
REQ-018 While pausa=1, the tick counter SHALL hold its value and no tick SHALL be generated.
REQ-019 On tick, every active slot with y>0 SHALL decrement y by 1, and every active slot with y=0 SHALL be deactivated, with x and y set to 0 (no underflow).
REQ-020 Inactive slots SHALL output x=0 and y=0.
REQ-021 acerto[k]=1 SHALL deactivate slot k in that cycle, with x and y set to 0; acerto on an inactive slot SHALL be ignored; acerto SHALL be honoured even while pausa=1.
REQ-022 If acerto[k] and a tick coincide, the kill SHALL take precedence over movement.
REQ-023 The spawn FSM SHALL have three states: LIVRE, ALOCA and RECARGA.
REQ-024 In LIVRE, the FSM SHALL go to ALOCA when disparo=1, pausa=0 and cheio=0; otherwise it SHALL stay in LIVRE.
REQ-025 In ALOCA, the FSM SHALL write the lowest-index inactive slot with x=xi and y=yi-OFFSET_Y (saturating to 0 if yi<OFFSET_Y).
REQ-026 In ALOCA, the FSM SHALL set that slot's ativo bit, pulse disparo_ack for that cycle, load the cooldown counter with RECARGA, and go to RECARGA.
REQ-027 If no slot is free in ALOCA, the FSM SHALL return to LIVRE with no ack.
REQ-028 A slot written in ALOCA SHALL NOT be decremented by a tick in the same cycle.
REQ-029 In RECARGA, the cooldown counter SHALL decrement once per tick, and the FSM SHALL go to LIVRE in the cycle after the counter reaches 0; disparo SHALL be ignored in this state.
REQ-030 If RECARGA=0, the FSM SHALL go from RECARGA to LIVRE on the next cycle.
REQ-031 cheio SHALL be combinational: &ativo.
REQ-032 The latency from disparo asserted in LIVRE to disparo_ack SHALL be 2 cycles.

Reset
REQ-033 reset=1 SHALL asynchronously force ativo=0, tiros_x=0, tiros_y=0, disparo_ack=0, the tick counter to 0, the cooldown counter to 0, and the FSM to LIVRE.
REQ-034 reiniciarJogo=1 SHALL produce the same state as reset on the next clock edge and SHALL override every other input that cycle, including mid-ALOCA and mid-RECARGA.
REQ-035 Reset asserted mid-operation SHALL discard any pending request; the requester SHALL re-present disparo.

Verification (DIV=4, RECARGA=2)
REQ-036 Fire with xi=100 and yi=200 -> disparo_ack pulses 2 cycles later; slot 0 has x=100, y=185, ativo=0001.
REQ-037 Slot 0 active at y=185 with 8 cycles elapsing -> y=183 (one decrement per 4 cycles).
REQ-038 Slot 0 at y=0 followed by a tick -> ativo[0]=0 and x=y=0, with no wrap to 1023.
REQ-039 disparo held continuously -> slots 0,1,2,3 fill in order, one per cooldown period, then cheio=1 and no further ack; acerto=0010 -> next shot lands in slot 1.
REQ-040 pausa=1 for 20 cycles with slots active -> positions and cooldown frozen; acerto=0001 during the pause -> slot 0 cleared.
REQ-041 reiniciarJogo pulsed during RECARGA with 3 slots active -> next cycle ativo=0000, FSM in LIVRE, and a new shot accepted immediately.
